// File: rtl/screen_seq_ctrl_if.sv
// Screen sequencer bus: VGA timing, mouse/game status and pixel sources in;
// current screen, muxed pixel and status flags out.
interface screen_seq_ctrl_if;
    logic        pclk_en;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic        MOUSE_LEFT;
    logic        mouse_on_start_button;
    logic        mouse_on_return_button;
    logic        game_solved;
    logic [11:0] pixel_menu_in;
    logic [11:0] pixel_game_in;
    logic [11:0] pixel_over_in;
    logic [1:0]  screen_state;
    logic [11:0] pixel_out;
    logic        game_start;
    logic        click_blocked;

    modport slave (
        input  pclk_en, h_cnt, v_cnt, valid, MOUSE_LEFT,
               mouse_on_start_button, mouse_on_return_button, game_solved,
               pixel_menu_in, pixel_game_in, pixel_over_in,
        output screen_state, pixel_out, game_start, click_blocked
    );

    modport master (
        output pclk_en, h_cnt, v_cnt, valid, MOUSE_LEFT,
               mouse_on_start_button, mouse_on_return_button, game_solved,
               pixel_menu_in, pixel_game_in, pixel_over_in,
        input  screen_state, pixel_out, game_start, click_blocked
    );
endinterface

// File: rtl/screen_seq_ctrl.sv
// MENU/GAME/OVER screen sequencer: requests are queued and applied only at the
// vertical-blank frame boundary, followed by a frame-counted click hold-off.
module screen_seq_ctrl #(
    parameter int HOLD_FRAMES = 8,
    parameter int VBLANK_LINE = 480
) (
    input logic              clk,
    input logic              rst_n,
    screen_seq_ctrl_if.slave bus
);
    localparam int CW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        MENU = 2'd0,
        GAME = 2'd1,
        OVER = 2'd2,
        BAD  = 2'd3
    } screen_t;

    screen_t       state, state_nxt;
    screen_t       pend_state, pend_state_nxt;
    screen_t       req_state;
    logic          pend, pend_nxt;
    logic          req;
    logic [CW-1:0] hold, hold_nxt;
    logic          mouse_prev;
    logic          fb, click;
    logic          start_q, start_nxt;
    logic [11:0]   pix_q, pix_nxt;

    assign fb    = bus.pclk_en && (bus.h_cnt == 10'd0) && (bus.v_cnt == 10'(VBLANK_LINE));
    assign click = mouse_prev && !bus.MOUSE_LEFT && (hold == '0);

    always_comb begin
        state_nxt      = state;
        pend_nxt       = pend;
        pend_state_nxt = pend_state;
        hold_nxt       = hold;
        req            = 1'b0;
        req_state      = MENU;
        pix_nxt        = pix_q;

        case (state)
            MENU:    if (click && bus.mouse_on_start_button)  begin req = 1'b1; req_state = GAME; end
            GAME:    if (bus.game_solved)                      begin req = 1'b1; req_state = OVER; end
            OVER:    if (click && bus.mouse_on_return_button) begin req = 1'b1; req_state = MENU; end
            default: ;
        endcase

        // A request seen on a boundary that already applies a pending change is
        // dropped; otherwise it queues and waits for the next boundary.
        if (state == BAD) begin
            state_nxt = MENU;
            pend_nxt  = 1'b0;
            hold_nxt  = HOLD_LOAD;
        end else if (fb && pend) begin
            state_nxt = pend_state;
            pend_nxt  = 1'b0;
            hold_nxt  = HOLD_LOAD;
        end else begin
            if (fb && hold != '0)
                hold_nxt = hold - CW'(1);
            if (req && !pend) begin
                pend_nxt       = 1'b1;
                pend_state_nxt = req_state;
            end
        end

        start_nxt = (state_nxt == GAME) && (state != GAME);

        if (bus.pclk_en) begin
            if (!bus.valid) pix_nxt = 12'h000;
            else begin
                case (state)
                    MENU:    pix_nxt = bus.pixel_menu_in;
                    GAME:    pix_nxt = bus.pixel_game_in;
                    OVER:    pix_nxt = bus.pixel_over_in;
                    default: pix_nxt = 12'h000;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= MENU;
            pend       <= 1'b0;
            pend_state <= MENU;
            hold       <= '0;
            mouse_prev <= 1'b0;
            start_q    <= 1'b0;
            pix_q      <= 12'h000;
        end else begin
            state      <= state_nxt;
            pend       <= pend_nxt;
            pend_state <= pend_state_nxt;
            hold       <= hold_nxt;
            mouse_prev <= bus.MOUSE_LEFT;
            start_q    <= start_nxt;
            pix_q      <= pix_nxt;
        end
    end

    assign bus.screen_state  = state;
    assign bus.pixel_out     = pix_q;
    assign bus.game_start    = start_q;
    assign bus.click_blocked = (hold != '0);
endmodule

// File: tb/tb_screen_seq_ctrl.sv
// Bench for screen_seq_ctrl: directed scenarios plus randomized traffic
// compared against a frame-level behavioural model.
module tb_screen_seq_ctrl;
    localparam int HOLD = 8;
    localparam int VBL  = 480;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    screen_seq_ctrl_if bus();

    screen_seq_ctrl #(.HOLD_FRAMES(HOLD), .VBLANK_LINE(VBL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // model state: current screen, queued request, frames left to block, pixel
    int   m_state = 0, m_pend = 0, m_pval = 0, m_hold = 0, m_prev = 0, m_start = 0;
    logic [11:0] m_pix = 12'h000;

    task automatic model_step();
        int old, want;
        bit fb, clk_ok;
        if (!rst_n) begin
            m_state = 0; m_pend = 0; m_pval = 0; m_hold = 0; m_prev = 0; m_start = 0; m_pix = 12'h000;
            return;
        end
        old = m_state;
        if (bus.pclk_en)
            m_pix = !bus.valid ? 12'h000 : (old == 0) ? bus.pixel_menu_in :
                    (old == 1) ? bus.pixel_game_in : bus.pixel_over_in;
        fb     = bus.pclk_en && bus.h_cnt == 0 && bus.v_cnt == VBL;
        clk_ok = (m_prev == 1) && !bus.MOUSE_LEFT && (m_hold == 0);
        want = -1;
        if (old == 0 && clk_ok && bus.mouse_on_start_button) want = 1;
        if (old == 1 && bus.game_solved) want = 2;
        if (old == 2 && clk_ok && bus.mouse_on_return_button) want = 0;
        m_start = 0;
        if (fb && m_pend == 1) begin
            m_state = m_pval; m_pend = 0; m_hold = HOLD; m_start = (m_state == 1);
        end else begin
            if (fb && m_hold > 0) m_hold--;
            if (want >= 0 && m_pend == 0) begin m_pend = 1; m_pval = want; end
        end
        m_prev = bus.MOUSE_LEFT;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic fb_tick();
        bus.pclk_en = 1'b1; bus.h_cnt = 10'd0; bus.v_cnt = 10'(VBL);
        tick();
        bus.h_cnt = 10'd5; bus.v_cnt = 10'd100;
    endtask

    task automatic set_idle();
        bus.pclk_en = 1'b1; bus.h_cnt = 10'd5; bus.v_cnt = 10'd100; bus.valid = 1'b0;
        bus.MOUSE_LEFT = 1'b0; bus.mouse_on_start_button = 1'b0;
        bus.mouse_on_return_button = 1'b0; bus.game_solved = 1'b0;
        bus.pixel_menu_in = 12'h111; bus.pixel_game_in = 12'h222; bus.pixel_over_in = 12'h333;
    endtask

    task automatic test_reset();
        set_idle();
        bus.MOUSE_LEFT = 1'b1;
        rst_n = 1'b0;
        tick(); tick();
        vectors += 4;
        if (bus.screen_state !== 2'd0) begin $display("FAIL reset_state got %0d want 0", bus.screen_state); miscompares++; end
        if (bus.pixel_out !== 12'h000) begin $display("FAIL reset_pixel got %h want 000", bus.pixel_out); miscompares++; end
        if (bus.game_start !== 1'b0) begin $display("FAIL reset_start got %b want 0", bus.game_start); miscompares++; end
        if (bus.click_blocked !== 1'b0) begin $display("FAIL reset_blocked got %b want 0", bus.click_blocked); miscompares++; end
        rst_n = 1'b1;
        bus.MOUSE_LEFT = 1'b0;
        tick();
    endtask

    task automatic test_menu_to_game();
        bus.mouse_on_start_button = 1'b1;
        bus.MOUSE_LEFT = 1'b1; tick();
        bus.MOUSE_LEFT = 1'b0; tick();
        bus.mouse_on_start_button = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.screen_state !== 2'd0) begin $display("FAIL m2g_wait got %0d want 0", bus.screen_state); miscompares++; end
        end
        fb_tick();
        vectors += 3;
        if (bus.screen_state !== 2'd1) begin $display("FAIL m2g_state got %0d want 1", bus.screen_state); miscompares++; end
        if (bus.game_start !== 1'b1) begin $display("FAIL m2g_start got %b want 1", bus.game_start); miscompares++; end
        if (bus.click_blocked !== 1'b1) begin $display("FAIL m2g_blocked got %b want 1", bus.click_blocked); miscompares++; end
        tick();
        vectors++;
        if (bus.game_start !== 1'b0) begin $display("FAIL m2g_pulse got %b want 0", bus.game_start); miscompares++; end
        for (int i = 0; i < 7; i++) begin fb_tick(); tick(); end
        vectors++;
        if (bus.click_blocked !== 1'b1) begin $display("FAIL m2g_hold7 got %b want 1", bus.click_blocked); miscompares++; end
        fb_tick();
        vectors++;
        if (bus.click_blocked !== 1'b0) begin $display("FAIL m2g_hold8 got %b want 0", bus.click_blocked); miscompares++; end
    endtask

    task automatic test_pixel();
        bus.pixel_game_in = 12'hFFF; bus.valid = 1'b0; bus.pclk_en = 1'b1; tick();
        vectors++;
        if (bus.pixel_out !== 12'h000) begin $display("FAIL pix_blank got %h want 000", bus.pixel_out); miscompares++; end
        bus.valid = 1'b1; tick();
        vectors++;
        if (bus.pixel_out !== 12'hFFF) begin $display("FAIL pix_game got %h want FFF", bus.pixel_out); miscompares++; end
        bus.pclk_en = 1'b0; bus.valid = 1'b0; bus.pixel_game_in = 12'h0AB;
        tick(); tick(); tick();
        vectors++;
        if (bus.pixel_out !== 12'hFFF) begin $display("FAIL pix_hold got %h want FFF", bus.pixel_out); miscompares++; end
        bus.pclk_en = 1'b1; bus.valid = 1'b1; tick();
        vectors++;
        if (bus.pixel_out !== 12'h0AB) begin $display("FAIL pix_update got %h want 0AB", bus.pixel_out); miscompares++; end
        bus.valid = 1'b0;
    endtask

    task automatic test_game_to_over();
        bus.mouse_on_start_button = 1'b1; bus.mouse_on_return_button = 1'b1;
        bus.MOUSE_LEFT = 1'b1; tick();
        bus.MOUSE_LEFT = 1'b0; tick();
        fb_tick(); tick();
        vectors++;
        if (bus.screen_state !== 2'd1) begin $display("FAIL g2o_click got %0d want 1", bus.screen_state); miscompares++; end
        bus.mouse_on_start_button = 1'b0; bus.mouse_on_return_button = 1'b0;
        bus.game_solved = 1'b1; tick();
        bus.game_solved = 1'b0; tick();
        vectors++;
        if (bus.screen_state !== 2'd1) begin $display("FAIL g2o_wait got %0d want 1", bus.screen_state); miscompares++; end
        fb_tick();
        vectors += 2;
        if (bus.screen_state !== 2'd2) begin $display("FAIL g2o_state got %0d want 2", bus.screen_state); miscompares++; end
        if (bus.game_start !== 1'b0) begin $display("FAIL g2o_start got %b want 0", bus.game_start); miscompares++; end
    endtask

    task automatic test_over_return();
        bus.mouse_on_return_button = 1'b1;
        bus.MOUSE_LEFT = 1'b1; tick();
        bus.MOUSE_LEFT = 1'b0; tick();
        fb_tick(); tick();
        vectors++;
        if (bus.screen_state !== 2'd2) begin $display("FAIL ret_blocked got %0d want 2", bus.screen_state); miscompares++; end
        for (int i = 0; i < 7; i++) begin fb_tick(); tick(); end
        vectors++;
        if (bus.click_blocked !== 1'b0) begin $display("FAIL ret_unblock got %b want 0", bus.click_blocked); miscompares++; end
        bus.MOUSE_LEFT = 1'b1; tick();
        bus.MOUSE_LEFT = 1'b0; tick();
        vectors++;
        if (bus.screen_state !== 2'd2) begin $display("FAIL ret_wait got %0d want 2", bus.screen_state); miscompares++; end
        fb_tick();
        vectors++;
        if (bus.screen_state !== 2'd0) begin $display("FAIL ret_state got %0d want 0", bus.screen_state); miscompares++; end
        bus.mouse_on_return_button = 1'b0;
    endtask

    task automatic test_fb_collision();
        for (int i = 0; i < HOLD; i++) begin fb_tick(); tick(); end
        bus.mouse_on_start_button = 1'b1;
        bus.MOUSE_LEFT = 1'b1; tick();
        bus.MOUSE_LEFT = 1'b0; tick();
        bus.MOUSE_LEFT = 1'b1; tick();
        bus.MOUSE_LEFT = 1'b0; fb_tick();
        vectors += 2;
        if (bus.screen_state !== 2'd1) begin $display("FAIL col_apply got %0d want 1", bus.screen_state); miscompares++; end
        if (bus.game_start !== 1'b1) begin $display("FAIL col_start got %b want 1", bus.game_start); miscompares++; end
        bus.mouse_on_start_button = 1'b0;
        tick();
        bus.game_solved = 1'b1; fb_tick();
        bus.game_solved = 1'b0;
        vectors++;
        if (bus.screen_state !== 2'd1) begin $display("FAIL col_defer got %0d want 1", bus.screen_state); miscompares++; end
        tick();
        fb_tick();
        vectors++;
        if (bus.screen_state !== 2'd2) begin $display("FAIL col_next got %0d want 2", bus.screen_state); miscompares++; end
    endtask

    task automatic test_reset_midflight();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        bus.mouse_on_start_button = 1'b1;
        bus.MOUSE_LEFT = 1'b1; tick();
        bus.MOUSE_LEFT = 1'b0;
        bus.pixel_menu_in = 12'h32E; bus.valid = 1'b1; bus.pclk_en = 1'b1; tick();
        vectors++;
        if (bus.pixel_out !== 12'h32E) begin $display("FAIL rmf_pixel got %h want 32E", bus.pixel_out); miscompares++; end
        rst_n = 1'b0; tick();
        vectors += 4;
        if (bus.screen_state !== 2'd0) begin $display("FAIL rmf_state got %0d want 0", bus.screen_state); miscompares++; end
        if (bus.pixel_out !== 12'h000) begin $display("FAIL rmf_pix got %h want 000", bus.pixel_out); miscompares++; end
        if (bus.game_start !== 1'b0) begin $display("FAIL rmf_start got %b want 0", bus.game_start); miscompares++; end
        if (bus.click_blocked !== 1'b0) begin $display("FAIL rmf_blocked got %b want 0", bus.click_blocked); miscompares++; end
        rst_n = 1'b1;
        bus.mouse_on_start_button = 1'b0; bus.valid = 1'b0;
        fb_tick();
        vectors += 2;
        if (bus.screen_state !== 2'd0) begin $display("FAIL rmf_nofb got %0d want 0", bus.screen_state); miscompares++; end
        if (bus.game_start !== 1'b0) begin $display("FAIL rmf_nopulse got %b want 0", bus.game_start); miscompares++; end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            bus.pclk_en = $urandom_range(0, 1) == 1;
            bus.h_cnt = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 799));
            bus.v_cnt = ($urandom_range(0, 3) == 0) ? 10'(VBL) : 10'($urandom_range(0, 524));
            bus.valid = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 3) == 0) bus.MOUSE_LEFT = ~bus.MOUSE_LEFT;
            bus.mouse_on_start_button  = $urandom_range(0, 3) != 0;
            bus.mouse_on_return_button = $urandom_range(0, 3) != 0;
            bus.game_solved = ($urandom_range(0, 29) == 0);
            bus.pixel_menu_in = 12'($urandom);
            bus.pixel_game_in = 12'($urandom);
            bus.pixel_over_in = 12'($urandom);
            tick();
            vectors += 4;
            if (bus.screen_state !== 2'(m_state)) begin
                $display("FAIL rnd_state cyc %0d got %0d want %0d", i, bus.screen_state, m_state); miscompares++;
            end
            if (bus.pixel_out !== m_pix) begin
                $display("FAIL rnd_pixel cyc %0d got %h want %h", i, bus.pixel_out, m_pix); miscompares++;
            end
            if (bus.game_start !== 1'(m_start)) begin
                $display("FAIL rnd_start cyc %0d got %b want %0d", i, bus.game_start, m_start); miscompares++;
            end
            if (bus.click_blocked !== (m_hold != 0)) begin
                $display("FAIL rnd_blocked cyc %0d got %b want %0d", i, bus.click_blocked, m_hold != 0); miscompares++;
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        test_reset();
        test_menu_to_game();
        test_pixel();
        test_game_to_over();
        test_over_return();
        test_fb_collision();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/screen_seq_ctrl.md
SCREEN_SEQ_CTRL -- requirements
Module: screen_seq_ctrl

Interface
REQ-001 The block SHALL have parameter HOLD_FRAMES, default 8, meaning the number of whole frames for which clicks are ignored after a screen change.
REQ-002 The block SHALL have parameter VBLANK_LINE, default 480, meaning the v_cnt value at which pending screen changes take effect.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 pclk_en  in  1  pixel-rate enable, high one clk cycle per pixel.
REQ-006 h_cnt, v_cnt  in  10 each  current VGA pixel coordinates.
REQ-007 valid  in  1  VGA active-area flag.
REQ-008 MOUSE_LEFT  in  1  left mouse button level.
REQ-009 mouse_on_start_button, mouse_on_return_button  in  1 each  mouse-over flags for the menu start button and the over-screen return button.
REQ-010 game_solved  in  1  level from the game core: the puzzle is complete.
REQ-011 pixel_menu_in, pixel_game_in, pixel_over_in  in  12 each  RGB444 outputs of the three screen pixel generators.
REQ-012 screen_state  out  2  current screen: 0 MENU, 1 GAME, 2 OVER.
REQ-013 pixel_out  out  12  registered RGB444 pixel to the VGA port.
REQ-014 game_start  out  1  one-clk pulse when GAME becomes the current screen.
REQ-015 click_blocked  out  1  high while the hold-off counter is non-zero.

Function
REQ-016 A click SHALL be a MOUSE_LEFT falling edge (previous sample 1, current sample 0), sampled every clk, with click_blocked low.
REQ-017 From MENU, a click with mouse_on_start_button high SHALL set the pending state to GAME.
REQ-018 From GAME, game_solved high SHALL set the pending state to OVER; clicks SHALL be ignored in GAME.
REQ-019 From OVER, a click with mouse_on_return_button high SHALL set the pending state to MENU.
REQ-020 The pending state SHALL be a 2-bit register plus a pending flag; a second request while pending SHALL be ignored (first request wins).
REQ-021 Frame boundary (fb) SHALL be the cycle with pclk_en=1, h_cnt=0 and v_cnt=VBLANK_LINE.
REQ-022 At fb with pending set: screen_state SHALL take the pending value and the pending flag SHALL clear in the same cycle.
REQ-023 A request arriving in the fb cycle itself SHALL be applied at the next fb.
REQ-024 game_start SHALL be high for exactly the one clk in which screen_state changes to 1.
REQ-025 On every screen_state change, the hold-off counter SHALL load HOLD_FRAMES; it SHALL decrement at each later fb and saturate at 0.
REQ-026 The counter SHALL be sized ceil(log2(HOLD_FRAMES+1)) bits; HOLD_FRAMES=0 SHALL mean no blocking.
REQ-027 pixel_out SHALL update only on pclk_en cycles: black (12'h000) if valid=0, otherwise the input selected by screen_state; it SHALL hold between enables, giving 1 pixel of latency.
REQ-028 screen_state value 3 is illegal and SHALL recover to MENU on the next clk; pixel_out SHALL be black while it is 3.
REQ-029 A simultaneous fb and click SHALL resolve as: the fb applies the existing pending state and loads hold-off, and the click is discarded.

Reset
REQ-030 With rst_n=0 at a clk edge, the block SHALL set screen_state=0, pending flag=0, hold-off=0, pixel_out=12'h000, game_start=0, click_blocked=0, and the MOUSE_LEFT history register=0.
REQ-031 Reset mid-transition SHALL discard any pending request; no game_start pulse SHALL follow reset release.

Verification
REQ-032 MENU, start hovered, MOUSE_LEFT 1->0 at v_cnt=100 -> screen_state stays 0 until fb at v_cnt=480,h_cnt=0, then becomes 1; game_start is 1 for one clk; click_blocked is high for 8 frames.
REQ-033 GAME, game_solved=1 -> OVER at next fb; clicks during GAME cause no change.
REQ-034 OVER, return hovered, click within 8 frames of entry -> ignored; same click after 8 fbs -> MENU at next fb.
REQ-035 valid=0 with pixel_game_in=12'hFFF in GAME -> pixel_out=12'h000; with valid=1 -> 12'hFFF one pclk_en later, held while pclk_en=0.
REQ-036 rst_n=0 asserted while a GAME pending request exists and pixel_out=12'h32E -> all outputs zero, and no transition at the next fb.
REQ-037 Click landing on the exact fb cycle with a pending request -> the pending request is applied and the click is lost; a request made in the fb cycle is deferred to the following fb.
